memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_memory_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one memory port between the instruction-fetch and data requesters.
//   Three-state FSM (IDLE / IGRANT / DGRANT). On a tie in IDLE, the requester
//   that was not served last wins. Out of reset the last-served requester is
//   taken to be the instruction side, so data wins the first tie.
//   A grant completes in the cycle the memory reports ACCESS. In that cycle
//   the granted wait output drops for exactly one cycle and the load output
//   shows ramload. FREE, BUSY and ERROR all keep the grant, so ERROR simply
//   retries. If the granted side withdraws its request, the grant is abandoned
//   with no completion pulse.
//   The ram-side and requester-side outputs are combinational. They are
//   decoded from the state register, so reset clears them immediately.
//
// Optional feature macro: MEMARB_STATS_EN
//   When defined, adds icount/dcount. These are saturating counters of
//   completed instruction and data transfers; abandoned grants are not
//   counted.
// -----------------------------------------------------------------------------
module memory_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    input  logic        halt,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEMARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGRANT = 2'd1;
    localparam logic [1:0] DGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic       last_data_r;     // 1: data was served last, 0: instruction
    logic       i_req_s;
    logic       d_req_s;
    logic       i_done_s;
    logic       d_done_s;

    // Request qualification: a halted core may not start a new fetch
    always_comb begin
        i_req_s = iREN & ~halt;
        d_req_s = dREN | dWEN;
    end

    // Next-state decode and completion detection
    always_comb begin
        next_state_s = state_r;
        i_done_s     = 1'b0;
        d_done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    next_state_s = last_data_r ? IGRANT : DGRANT;
                end else if (d_req_s) begin
                    next_state_s = DGRANT;
                end else if (i_req_s) begin
                    next_state_s = IGRANT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IGRANT: begin
                // halt is deliberately ignored here so a started fetch completes
                if (!iREN) begin
                    next_state_s = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    i_done_s     = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = IGRANT;
                end
            end
            DGRANT: begin
                if (!d_req_s) begin
                    next_state_s = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    d_done_s     = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DGRANT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and last-served registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            last_data_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (i_done_s) begin
                last_data_r <= 1'b0;
            end else if (d_done_s) begin
                last_data_r <= 1'b1;
            end else begin
                last_data_r <= last_data_r;
            end
        end
    end

    // Output decode: memory port mux plus requester wait/load responses
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state_r)
            IDLE: begin
                ramREN = 1'b0;
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramWEN  = 1'b0;
                ramaddr = iaddr;
                iwait   = ~i_done_s;
                iload   = i_done_s ? ramload : 32'd0;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;   // a store takes precedence over a load
                dwait    = ~d_done_s;
                dload    = d_done_s ? ramload : 32'd0;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

`ifdef MEMARB_STATS_EN
    logic [31:0] icount_r;
    logic [31:0] dcount_r;

    // Saturating completion counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            icount_r <= 32'd0;
            dcount_r <= 32'd0;
        end else begin
            if (i_done_s && (icount_r != 32'hFFFF_FFFF)) begin
                icount_r <= icount_r + 32'd1;
            end else begin
                icount_r <= icount_r;
            end
            if (d_done_s && (dcount_r != 32'hFFFF_FFFF)) begin
                dcount_r <= dcount_r + 32'd1;
            end else begin
                dcount_r <= dcount_r;
            end
        end
    end

    // Expose the counters
    always_comb begin
        icount = icount_r;
        dcount = dcount_r;
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   This bench checks memory_arbiter on every cycle against a transaction-level
//   model. The model tracks who owns the memory port (none / instruction /
//   data), who was served last, and the completion counts. Directed scenarios
//   cover the notable cases. A randomized phase then follows.
//   Compile with +define+MEMARB_STATS_EN to also check icount/dcount.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        halt;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef MEMARB_STATS_EN
    logic [31:0] icount;
    logic [31:0] dcount;
`endif

    memory_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .halt     (halt),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEMARB_STATS_EN
        ,
        .icount   (icount),
        .dcount   (dcount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: port owner (0 none, 1 instruction, 2 data)
    int          owner;
    bit          last_data;
    logic [31:0] icnt;
    logic [31:0] dcnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner     = 0;
        last_data = 1'b0;
        icnt      = 32'd0;
        dcnt      = 32'd0;
    endtask

    task automatic idle_inputs();
        iREN     = 1'b0;
        iaddr    = 32'd0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'd0;
        dstore   = 32'd0;
        halt     = 1'b0;
        ramload  = 32'd0;
        ramstate = 2'd0;
    endtask

    // Settle combinational outputs mid-cycle and compare them with the model
    task automatic settle();
        logic        e_ren, e_wen, e_iwait, e_dwait, i_done, d_done;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        #2;
        if (RST) model_reset();
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
        e_iwait = 1'b1; e_dwait = 1'b1; e_iload = 32'd0; e_dload = 32'd0;
        i_done = 1'b0; d_done = 1'b0;
        if (owner == 1) begin
            i_done  = iREN && (ramstate == 2'd2);
            e_ren   = 1'b1;
            e_addr  = iaddr;
            e_iwait = !i_done;
            e_iload = i_done ? ramload : 32'd0;
        end else if (owner == 2) begin
            d_done  = (dREN || dWEN) && (ramstate == 2'd2);
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            e_dwait = !d_done;
            e_dload = d_done ? ramload : 32'd0;
        end
        check_eq("ramREN",  32'(ramREN), 32'(e_ren));
        check_eq("ramWEN",  32'(ramWEN), 32'(e_wen));
        check_eq("ramaddr", ramaddr, e_addr);
        if (owner != 1) check_eq("ramstore", ramstore, e_store);
        check_eq("iwait",   32'(iwait), 32'(e_iwait));
        check_eq("dwait",   32'(dwait), 32'(e_dwait));
        check_eq("iload",   iload, e_iload);
        check_eq("dload",   dload, e_dload);
`ifdef MEMARB_STATS_EN
        check_eq("icount",  icount, icnt);
        check_eq("dcount",  dcount, dcnt);
`endif
    endtask

    // Take the clock edge and advance the model with the inputs that were applied
    task automatic advance();
        bit want_i, want_d;
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else if (owner == 0) begin
            want_i = iREN && !halt;
            want_d = dREN || dWEN;
            if (want_i && want_d) owner = last_data ? 1 : 2;
            else if (want_d)      owner = 2;
            else if (want_i)      owner = 1;
        end else if (owner == 1) begin
            if (!iREN) owner = 0;
            else if (ramstate == 2'd2) begin
                owner = 0; last_data = 1'b0;
                if (icnt != 32'hFFFF_FFFF) icnt = icnt + 32'd1;
            end
        end else begin
            if (!(dREN || dWEN)) owner = 0;
            else if (ramstate == 2'd2) begin
                owner = 0; last_data = 1'b1;
                if (dcnt != 32'hFFFF_FFFF) dcnt = dcnt + 32'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) begin
            settle();
            advance();
        end
        RST = 1'b0;
    endtask

    initial begin
        int          lows;
        int          ncomp;
        logic [31:0] order;

        RST = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();

        // Fetch with two BUSY cycles, then ACCESS
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1; lows = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin ramstate = 2'd2; ramload = 32'hDEAD_BEEF; end
            settle();
            if (!iwait) lows++;
            if (c == 3) begin
                check_eq("s26_iload", iload, 32'hDEAD_BEEF);
                check_eq("s26_addr", ramaddr, 32'h40);
            end
            advance();
        end
        iREN = 1'b0; ramstate = 2'd0;
        settle();
        if (!iwait) lows++;
        check_eq("s26_idle_ren", 32'(ramREN), 32'd0);
        advance();
        check_eq("s26_one_pulse", 32'(lows), 32'd1);

        // Simultaneous fetch and store after reset: data first, then fetch
        do_reset();
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        ramstate = 2'd1;
        settle(); advance();
        ramstate = 2'd2; ramload = 32'h0;
        settle();
        check_eq("s27_wen", 32'(ramWEN), 32'd1);
        check_eq("s27_store", ramstore, 32'h1234);
        check_eq("s27_daddr", ramaddr, 32'h80);
        check_eq("s27_dwait", 32'(dwait), 32'd0);
        check_eq("s27_iwait", 32'(iwait), 32'd1);
        advance();
        dWEN = 1'b0; ramstate = 2'd1;
        settle(); advance();
        ramstate = 2'd2; ramload = 32'hCAFE_F00D;
        settle();
        check_eq("s27_igrant_ren", 32'(ramREN), 32'd1);
        check_eq("s27_igrant_addr", ramaddr, 32'h44);
        check_eq("s27_iwait", 32'(iwait), 32'd0);
        check_eq("s27_iload", iload, 32'hCAFE_F00D);
        advance();
        iREN = 1'b0; ramstate = 2'd0;

        // Continuous contention with instant ACCESS: grants alternate
        do_reset();
        iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200;
        ramstate = 2'd2; ramload = 32'h5A5A_5A5A;
        order = 32'd0; ncomp = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (!dwait) begin order = {order[27:0], 4'h1}; ncomp++; end
            if (!iwait) begin order = {order[27:0], 4'h2}; ncomp++; end
            advance();
        end
        check_eq("s28_order", order, 32'h0000_1212);
        check_eq("s28_count", 32'(ncomp), 32'd4);
        idle_inputs();

        // ERROR retries, then a later access is abandoned mid-BUSY
        do_reset();
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1; lows = 0;
        settle(); advance();
        ramstate = 2'd3;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("s29_err_dwait", 32'(dwait), 32'd1);
            advance();
        end
        ramstate = 2'd2; ramload = 32'h0BAD_F00D;
        settle();
        if (!dwait) lows++;
        check_eq("s29_dload", dload, 32'h0BAD_F00D);
        advance();
        dREN = 1'b0; ramstate = 2'd0;
        settle(); advance();
        check_eq("s29_single", 32'(lows), 32'd1);
        dREN = 1'b1; ramstate = 2'd1;
        settle(); advance();
        settle(); advance();
        dREN = 1'b0;
        settle();
        check_eq("s29_abort_dwait", 32'(dwait), 32'd1);
        advance();
        settle();
        check_eq("s29_idle_ren", 32'(ramREN), 32'd0);
        check_eq("s29_idle_dwait", 32'(dwait), 32'd1);
`ifdef MEMARB_STATS_EN
        check_eq("s29_dcount", dcount, 32'd1);
`endif
        advance();

        // halt blocks new fetches; reset in the middle of a data grant
        do_reset();
        halt = 1'b1; iREN = 1'b1; ramstate = 2'd2;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_eq("s30_halt_ren", 32'(ramREN), 32'd0);
            check_eq("s30_halt_iwait", 32'(iwait), 32'd1);
            advance();
        end
        halt = 1'b0; iREN = 1'b0;
        dWEN = 1'b1; daddr = 32'h400; dstore = 32'h55; ramstate = 2'd1;
        settle(); advance();
        settle();
        check_eq("s30_pre_wen", 32'(ramWEN), 32'd1);
        RST = 1'b1;
        #1;
        check_eq("s30_rst_wen", 32'(ramWEN), 32'd0);
        check_eq("s30_rst_addr", ramaddr, 32'd0);
        check_eq("s30_rst_store", ramstore, 32'd0);
        check_eq("s30_rst_dwait", 32'(dwait), 32'd1);
        advance();
        dWEN = 1'b0;
        settle(); advance();
        RST = 1'b0;

        // Randomized traffic checked against the model every cycle
        do_reset();
        for (int c = 0; c < 600; c++) begin
            iREN     = iREN ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            dREN     = dREN ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            dWEN     = dWEN ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
            halt     = ($urandom_range(0, 4) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            if (owner == 1 && !iREN && ramstate == 2'd2) ramstate = 2'd1;
            if (owner == 2 && !(dREN || dWEN) && ramstate == 2'd2) ramstate = 2'd1;
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
